step_phase_decoder: RTL and testbench
=====================================

// Module: step_phase_decoder
// PURPOSE
//  Decodes the 4-bit coil drive code produced by the stepper controller back into
//  step events and an absolute position count. One instance sits on each motor's
//  coil bus as an independent position tracker for the main module, and flags
//  illegal phase sequences.
// PARAMETERS
//  POS_W          12  width of position counter (matches 12-bit step requests)
//  STABLE_CYCLES  4   consecutive identical samples before a code is accepted (>=1)
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  rst_n      in   1      synchronous reset, active-low
//  state      in   4      coil drive code observed on motor bus
//  home       in   1      boundary/home switch; sync clear of position
//  fault_clr  in   1      clears sticky fault
//  position   out  POS_W  absolute step count
//  step_pulse out  1      one-cycle pulse per decoded step
//  step_dir   out  1      direction of last step: 0 forward, 1 backward
//  idle       out  1      accepted code is 4'b0000 (coils off)
//  fault      out  1      sticky illegal-sequence flag
// BEHAVIOUR
//  - Phase ring, forward order: 1100 -> 0110 -> 0011 -> 1001 -> 1100; backward is reverse.
//  - Reset (rst_n=0 at posedge): position=0, step_pulse=0, step_dir=0, idle=1,
//    fault=0, reference phase invalid, stability counter=0, input register=0000.
//  - Input stage: state registered once (s_q). Counter counts consecutive cycles with
//    s_q equal to the candidate code; any change restarts the count at 1 with the new candidate.
//  - Code accepted when count reaches STABLE_CYCLES; accepted only once per run (no re-accept
//    while held). Total latency: state change -> step_pulse/position = STABLE_CYCLES+1 cycles.
//  - On acceptance of code C, with reference phase R:
//    * C=0000: idle=1; R retained; no step.
//    * C valid phase, R invalid: R<=C; idle=0; no step (first phase after reset).
//    * C==R: idle=0; no step (re-energise same phase).
//    * C = forward successor of R: position+1, step_pulse=1, step_dir=0, R<=C.
//    * C = backward successor of R: position-1, step_pulse=1, step_dir=1, R<=C.
//    * C = opposite phase of R (two steps away): fault=1, R<=C, no position change.
//    * any other code: fault=1, R unchanged, idle=0, no position change.
//  - step_pulse is high exactly one cycle per step; otherwise 0.
//  - Position arithmetic modulo 2^POS_W (wraps 0 -> all-ones and back) unless SAT enabled.
//  - home=1: position<=0 that cycle; beats a simultaneous step (step_pulse/step_dir still
//    update). home does not affect R, fault or idle.
//  - fault sticky; fault_clr=1 clears it; if a new fault occurs in the same cycle, fault stays 1.
//  - Reset mid-stability-count or mid-step discards everything; first phase afterwards only
//    re-establishes R.
// CONFIGURATION
//  STEP_PHASE_DECODER_SAT_EN defined: position saturates; +1 at all-ones and -1 at 0 leave
//    position unchanged, step_pulse/step_dir still issued.
//  Undefined (default): modulo wrap-around as above.
// TESTING
//  1 rst_n=0 2 cycles, state=1100 held -> position=0, idle=0 after latency, no step_pulse.
//  2 STABLE_CYCLES=4: 1100,0110,0011,1001,1100 each held 6 cycles -> four pulses, dir=0,
//    position=4; each pulse 5 cycles after its code change.
//  3 from position=0, R=1100, apply 1001 -> position=all-ones (4095), dir=1; with SAT_EN
//    defined -> position stays 0, pulse still seen.
//  4 0110 glitch 2 cycles inside held 1100 then 1100 again -> no step, no fault, position unchanged.
//  5 R=1100, apply 0011 -> fault=1, position unchanged; apply 1010 -> fault stays; fault_clr -> 0.
//  6 home=1 in same cycle as forward step at position=7 -> position=0, step_pulse=1, dir=0.

Source files
------------

// File: rtl/step_phase_decoder.sv
// rtl/step_phase_decoder.sv - coil drive code to step/position decoder (optional STEP_PHASE_DECODER_SAT_EN)
module step_phase_decoder #(
    parameter int POS_W         = 12,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       state,
    input  logic             home,
    input  logic             fault_clr,
    output logic [POS_W-1:0] position,
    output logic             step_pulse,
    output logic             step_dir,
    output logic             idle,
    output logic             fault
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // {valid, ring index}; index increases in the forward direction
    function automatic logic [2:0] phase_idx(input logic [3:0] c);
        case (c)
            4'b1100: phase_idx = 3'b100;
            4'b0110: phase_idx = 3'b101;
            4'b0011: phase_idx = 3'b110;
            4'b1001: phase_idx = 3'b111;
            default: phase_idx = 3'b000;
        endcase
    endfunction

    logic [3:0]       s_q, s_d;
    logic [3:0]       cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       ref_q, ref_d;
    logic             ref_valid_q, ref_valid_d;
    logic [POS_W-1:0] position_q, position_d;
    logic             pulse_q, pulse_d;
    logic             dir_q, dir_d;
    logic             idle_q, idle_d;
    logic             fault_q, fault_d;

    logic             accept;
    logic             new_fault;
    logic             inc;
    logic             dec;
    logic [2:0]       pc;
    logic [1:0]       diff;

    always_comb begin
        s_d         = state;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        ref_d       = ref_q;
        ref_valid_d = ref_valid_q;
        position_d  = position_q;
        pulse_d     = 1'b0;
        dir_d       = dir_q;
        idle_d      = idle_q;
        new_fault   = 1'b0;
        inc         = 1'b0;
        dec         = 1'b0;
        pc          = phase_idx(s_q);
        diff        = pc[1:0] - ref_q;

        // counter saturates at CNT_MAX so a held code is accepted only once
        if (s_q != cand_q) begin
            cand_d = s_q;
            cnt_d  = CNT_ONE;
            accept = (CNT_ONE == CNT_MAX);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d  = cnt_q + CNT_ONE;
            accept = (cnt_q + CNT_ONE == CNT_MAX);
        end

        if (accept) begin
            if (s_q == 4'b0000) begin
                idle_d = 1'b1;
            end else begin
                idle_d = 1'b0;
                if (!pc[2]) begin
                    new_fault = 1'b1;
                end else if (!ref_valid_q) begin
                    ref_d       = pc[1:0];
                    ref_valid_d = 1'b1;
                end else begin
                    case (diff)
                        2'd1: begin
                            inc     = 1'b1;
                            pulse_d = 1'b1;
                            dir_d   = 1'b0;
                            ref_d   = pc[1:0];
                        end
                        2'd3: begin
                            dec     = 1'b1;
                            pulse_d = 1'b1;
                            dir_d   = 1'b1;
                            ref_d   = pc[1:0];
                        end
                        2'd2: begin
                            new_fault = 1'b1;
                            ref_d     = pc[1:0];
                        end
                        default: ;
                    endcase
                end
            end
        end

`ifdef STEP_PHASE_DECODER_SAT_EN
        if (inc && (position_q != {POS_W{1'b1}})) position_d = position_q + POS_W'(1);
        if (dec && (position_q != '0))            position_d = position_q - POS_W'(1);
`else
        if (inc) position_d = position_q + POS_W'(1);
        if (dec) position_d = position_q - POS_W'(1);
`endif
        if (home) position_d = '0;

        fault_d = (fault_q & ~fault_clr) | new_fault;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q         <= 4'b0000;
            cand_q      <= 4'b0000;
            cnt_q       <= '0;
            ref_q       <= 2'd0;
            ref_valid_q <= 1'b0;
            position_q  <= '0;
            pulse_q     <= 1'b0;
            dir_q       <= 1'b0;
            idle_q      <= 1'b1;
            fault_q     <= 1'b0;
        end else begin
            s_q         <= s_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
            position_q  <= position_d;
            pulse_q     <= pulse_d;
            dir_q       <= dir_d;
            idle_q      <= idle_d;
            fault_q     <= fault_d;
        end
    end

    assign position   = position_q;
    assign step_pulse = pulse_q;
    assign step_dir   = dir_q;
    assign idle       = idle_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_step_phase_decoder.sv
// tb/tb_step_phase_decoder.sv - directed and random bench for step_phase_decoder (honours STEP_PHASE_DECODER_SAT_EN)
module tb_step_phase_decoder;

    localparam int POS_W  = 12;
    localparam int STABLE = 4;
    localparam int MODV   = 1 << POS_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       state;
    logic             home;
    logic             fault_clr;
    logic [POS_W-1:0] position;
    logic             step_pulse;
    logic             step_dir;
    logic             idle;
    logic             fault;

    always #5 clk = ~clk;

    step_phase_decoder #(.POS_W(POS_W), .STABLE_CYCLES(STABLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .home      (home),
        .fault_clr (fault_clr),
        .position  (position),
        .step_pulse(step_pulse),
        .step_dir  (step_dir),
        .idle      (idle),
        .fault     (fault)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] ring [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

    logic [3:0] hist [$];
    logic [3:0] pending;
    int         mpos;
    bit         mpulse, mdir, midle, mfault, rvalid;
    int         ridx;

    function automatic int find_phase(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (ring[i] == c) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [3:0] st, input bit hm, input bit fc, input bit rn);
        int n;
        int pi;
        int d;
        bit nf;
        if (!rn) begin
            hist.delete();
            pending = 4'b0000;
            mpos = 0; mpulse = 0; mdir = 0; midle = 1; mfault = 0; rvalid = 0; ridx = 0;
            return;
        end
        hist.push_back(pending);
        if (hist.size() > 16) void'(hist.pop_front());
        n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != pending) break;
            n++;
        end
        mpulse = 0;
        nf = 0;
        if (n == STABLE) begin
            pi = find_phase(pending);
            if (pending == 4'b0000) begin
                midle = 1;
            end else if (pi < 0) begin
                midle = 0;
                nf = 1;
            end else if (!rvalid) begin
                midle = 0;
                rvalid = 1;
                ridx = pi;
            end else begin
                midle = 0;
                d = (pi - ridx + 4) % 4;
                if (d == 1) begin
`ifdef STEP_PHASE_DECODER_SAT_EN
                    if (mpos < MODV - 1) mpos = mpos + 1;
`else
                    mpos = (mpos + 1) % MODV;
`endif
                    mpulse = 1; mdir = 0; ridx = pi;
                end else if (d == 3) begin
`ifdef STEP_PHASE_DECODER_SAT_EN
                    if (mpos > 0) mpos = mpos - 1;
`else
                    mpos = (mpos + MODV - 1) % MODV;
`endif
                    mpulse = 1; mdir = 1; ridx = pi;
                end else if (d == 2) begin
                    nf = 1; ridx = pi;
                end
            end
        end
        if (hm) mpos = 0;
        mfault = (mfault && !fc) || nf;
        pending = st;
    endtask

    task automatic cyc(input logic [3:0] st, input bit hm, input bit fc, input bit rn);
        state = st; home = hm; fault_clr = fc; rst_n = rn;
        @(posedge clk);
        model_edge(st, hm, fc, rn);
        @(negedge clk);
        check("position",   32'(position),   32'(mpos));
        check("step_pulse", 32'(step_pulse), 32'(mpulse));
        check("step_dir",   32'(step_dir),   32'(mdir));
        check("idle",       32'(idle),       32'(midle));
        check("fault",      32'(fault),      32'(mfault));
    endtask

    task automatic hold(input logic [3:0] st, input int n, output int pulse_at);
        pulse_at = 0;
        for (int i = 1; i <= n; i++) begin
            cyc(st, 0, 0, 1);
            if (step_pulse === 1'b1 && pulse_at == 0) pulse_at = i;
        end
    endtask

    initial begin
        int pa;
        int n;
        int r;
        logic [3:0] code;
        logic [3:0] seq [4] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};

        state = 4'b0000; home = 0; fault_clr = 0; rst_n = 0;
        @(negedge clk);

        // reset with a phase held, then first phase only establishes the reference
        cyc(4'b1100, 0, 0, 0);
        cyc(4'b1100, 0, 0, 0);
        check("rst_idle", 32'(idle), 32'd1);
        hold(4'b1100, 8, pa);
        check("t1_no_pulse", 32'(pa), 32'd0);
        check("t1_idle", 32'(idle), 32'd0);
        check("t1_pos", 32'(position), 32'd0);

        // backward from zero
        hold(4'b1001, 6, pa);
        check("t3_pulse_at", 32'(pa), 32'd5);
        check("t3_dir", 32'(step_dir), 32'd1);
`ifdef STEP_PHASE_DECODER_SAT_EN
        check("t3_pos", 32'(position), 32'd0);
`else
        check("t3_pos", 32'(position), 32'd4095);
`endif

        // four forward steps
        cyc(4'b0000, 0, 0, 0);
        cyc(4'b0000, 0, 0, 0);
        hold(4'b1100, 6, pa);
        for (int i = 0; i < 4; i++) begin
            hold(seq[i], 6, pa);
            check("t2_pulse_at", 32'(pa), 32'd5);
            check("t2_dir", 32'(step_dir), 32'd0);
        end
        check("t2_pos", 32'(position), 32'd4);

        // short glitch is ignored
        hold(4'b0110, 2, pa);
        hold(4'b1100, 6, pa);
        check("t4_no_pulse", 32'(pa), 32'd0);
        check("t4_pos", 32'(position), 32'd4);
        check("t4_fault", 32'(fault), 32'd0);

        // opposite phase and illegal code faults, then clear
        hold(4'b0011, 6, pa);
        check("t5_fault", 32'(fault), 32'd1);
        check("t5_pos", 32'(position), 32'd4);
        hold(4'b1010, 6, pa);
        check("t5_fault_stays", 32'(fault), 32'd1);
        cyc(4'b1010, 0, 1, 1);
        check("t5_fault_clr", 32'(fault), 32'd0);

        // home coincident with a forward step at position 7
        hold(4'b1001, 6, pa);
        hold(4'b1100, 6, pa);
        hold(4'b0110, 6, pa);
        check("t6_pos7", 32'(position), 32'd7);
        for (int i = 1; i <= 6; i++) begin
            cyc(4'b0011, (i == 5), 0, 1);
            if (i == 5) begin
                check("t6_pos", 32'(position), 32'd0);
                check("t6_pulse", 32'(step_pulse), 32'd1);
                check("t6_dir", 32'(step_dir), 32'd0);
            end
        end

        // random walk against the reference model
        for (int s = 0; s < 400; s++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       code = ring[$urandom_range(0, 3)];
            else if (r == 7) code = 4'b0000;
            else             code = 4'($urandom);
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++)
                cyc(code, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                    !($urandom_range(0, 149) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
